// File: rtl/pong_pkg.sv
// Shared types and display constants for the pong match logic.
package pong_pkg;

  // Match sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int LCD_WIDTH  = 240;
  localparam int LCD_HEIGHT = 320;
  localparam int MAX_SCORE  = 10;
  localparam int SCORE_W    = 4;
  localparam int BALL_Y_W   = 9;

endpackage : pong_pkg

// File: rtl/pong_edge_detect.sv
// Registered rising-edge detector for the start request.
module pong_edge_detect (
  input  logic clock,
  input  logic resetApp,
  input  logic start,
  output logic start_rise
);

  // start_low remembers that start was seen low on the previous clock.
  // Clearing it on reset means a start held high across reset never
  // looks like a fresh press; the button must be released first.
  logic start_low;

  // Track the previous level and register the edge pulse.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      start_low  <= 1'b0;
      start_rise <= 1'b0;
    end else begin
      // NOTE: non-blocking so both registers see the pre-edge value of start_low.
      start_low  <= ~start;
      start_rise <= start & start_low;
    end
  end

endmodule : pong_edge_detect

// File: rtl/pong_score_keeper.sv
// Match controller: goal detection, scores, serve timing and game over.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int LCD_HEIGHT  = pong_pkg::LCD_HEIGHT,
  parameter int MAX_SCORE   = pong_pkg::MAX_SCORE,
  parameter int GOAL_TOP    = 2,
  parameter int GOAL_BOTTOM = LCD_HEIGHT - 3,
  parameter int SERVE_TICKS = 60
) (
  input  logic                clock,
  input  logic                resetApp,
  input  logic                game_tick,
  input  logic                start,
  input  logic [BALL_Y_W-1:0] ball_y,
  output logic [SCORE_W-1:0]  score_1,
  output logic [SCORE_W-1:0]  score_2,
  output logic                ball_hold,
  output logic                ball_rearm,
  output logic                serve_dir,
  output logic                game_over,
  output logic                winner
);

  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  // Sized copies of the integer parameters so every compare is width-matched.
  localparam logic [BALL_Y_W-1:0] GOAL_TOP_Y    = BALL_Y_W'(GOAL_TOP);
  localparam logic [BALL_Y_W-1:0] GOAL_BOTTOM_Y = BALL_Y_W'(GOAL_BOTTOM);
  localparam logic [SCORE_W-1:0]  WIN_SCORE     = SCORE_W'(MAX_SCORE);
  localparam logic [CNT_W-1:0]    SERVE_LAST    = CNT_W'(SERVE_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] serve_cnt;
  logic             start_rise;

  pong_edge_detect u_start_edge (
    .clock      (clock),
    .resetApp   (resetApp),
    .start      (start),
    .start_rise (start_rise)
  );

  // Match FSM with all outputs registered alongside the state.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state      <= IDLE;
      serve_cnt  <= '0;
      score_1    <= '0;
      score_2    <= '0;
      ball_hold  <= 1'b1;
      ball_rearm <= 1'b0;
      serve_dir  <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      // ball_rearm is a single-clock pulse; it only rises where set below.
      ball_rearm <= 1'b0;

      case (state)
        IDLE, OVER: begin
          ball_hold <= 1'b1;
          if (start_rise) begin
            score_1    <= '0;
            score_2    <= '0;
            serve_dir  <= 1'b0;
            ball_rearm <= 1'b1;
            serve_cnt  <= '0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
            state      <= SERVE;
          end
        end

        SERVE: begin
          ball_hold <= 1'b1;
          if (game_tick) begin
            if (serve_cnt == SERVE_LAST) begin
              ball_hold <= 1'b0;
              state     <= PLAY;
            end else begin
              serve_cnt <= serve_cnt + CNT_W'(1);
            end
          end
        end

        PLAY: begin
          if (game_tick) begin
            // Top goal is tested first so it wins if both compares ever hit.
            if (ball_y <= GOAL_TOP_Y) begin
              if (score_1 != WIN_SCORE) score_1 <= score_1 + SCORE_W'(1);
              serve_dir <= 1'b1;
              ball_hold <= 1'b1;
              state     <= POINT;
            end else if (ball_y >= GOAL_BOTTOM_Y) begin
              if (score_2 != WIN_SCORE) score_2 <= score_2 + SCORE_W'(1);
              serve_dir <= 1'b0;
              ball_hold <= 1'b1;
              state     <= POINT;
            end
          end
        end

        POINT: begin
          ball_hold <= 1'b1;
          if (score_1 == WIN_SCORE || score_2 == WIN_SCORE) begin
            game_over <= 1'b1;
            winner    <= (score_2 == WIN_SCORE);
            state     <= OVER;
          end else begin
            ball_rearm <= 1'b1;
            serve_cnt  <= '0;
            state      <= SERVE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : pong_score_keeper
